// File: rtl/bus_master_queued.sv
// Queued two-phase bus master: client commands are buffered in a FIFO and
// issued one at a time (address phase, then data phase), with a per-phase
// ready timeout and one response per command in command order.
module bus_master_queued #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_write,
  input  logic [ADDR_W-1:0]              cmd_addr,
  input  logic [DATA_W-1:0]              cmd_wdata,
  output logic                           bus_valid,
  input  logic                           bus_ready,
  output logic                           bus_read,
  output logic                           bus_write,
  output logic [ADDR_W-1:0]              bus_addr,
  output logic [DATA_W-1:0]              bus_write_data,
  input  logic [DATA_W-1:0]              bus_read_data,
  output logic                           rsp_valid,
  output logic                           rsp_write,
  output logic [DATA_W-1:0]              rsp_rdata,
  output logic                           rsp_error,
  output logic [$clog2(CMD_DEPTH+1)-1:0] cmd_count,
  output logic                           busy
);

  localparam int unsigned PTR_W = $clog2(CMD_DEPTH);
  localparam int unsigned CNT_W = $clog2(CMD_DEPTH + 1);
  localparam int unsigned TO_W  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  cmd_t              mem_q [CMD_DEPTH];
  cmd_t              mem_d [CMD_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        state_q, state_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              bus_valid_q, bus_valid_d;
  logic              bus_read_q, bus_read_d;
  logic              bus_write_q, bus_write_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_error_q, rsp_error_d;

  logic full;
  logic push;
  logic pop;
  logic timeout_hit;
  cmd_t head;

  // No pass-through: a full FIFO refuses a push even when popping.
  assign full        = (count_q == CNT_W'(CMD_DEPTH));
  assign push        = cmd_valid && !full;
  assign head        = mem_q[rd_ptr_q];
  assign timeout_hit = (TIMEOUT != 0) && (to_q == TO_W'(TIMEOUT));

  assign cmd_ready      = !full;
  assign cmd_count      = count_q;
  assign busy           = (state_q != S_IDLE) || (count_q != '0);
  assign bus_valid      = bus_valid_q;
  assign bus_read       = bus_read_q;
  assign bus_write      = bus_write_q;
  assign bus_addr       = bus_addr_q;
  assign bus_write_data = bus_wdata_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_write      = rsp_write_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_error      = rsp_error_q;

  // FIFO storage and pointer/occupancy next-state.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Transaction FSM: issue head command, run both phases, produce response.
  always_comb begin
    state_d     = state_q;
    to_d        = to_q;
    pop         = 1'b0;
    bus_valid_d = bus_valid_q;
    bus_read_d  = bus_read_q;
    bus_write_d = bus_write_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_error_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus_valid_d = 1'b0;
        bus_read_d  = 1'b0;
        bus_write_d = 1'b0;
        to_d        = '0;
        if (count_q != '0) begin
          pop         = 1'b1;
          bus_valid_d = 1'b1;
          bus_read_d  = !head.write;
          bus_write_d = head.write;
          bus_addr_d  = head.addr;
          bus_wdata_d = head.wdata;
          state_d     = S_ADDR;
        end
      end
      S_ADDR, S_DATA: begin
        if (bus_ready) begin
          to_d = '0;
          if (state_q == S_ADDR) begin
            state_d = S_DATA;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_write_d = bus_write_q;
            rsp_rdata_d = bus_read_q ? bus_read_data : '0;
            bus_valid_d = 1'b0;
            bus_read_d  = 1'b0;
            bus_write_d = 1'b0;
            state_d     = S_IDLE;
          end
        end else if (timeout_hit) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          rsp_write_d = bus_write_q;
          bus_valid_d = 1'b0;
          bus_read_d  = 1'b0;
          bus_write_d = 1'b0;
          to_d        = '0;
          state_d     = S_IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      to_q        <= '0;
      bus_valid_q <= 1'b0;
      bus_read_q  <= 1'b0;
      bus_write_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      to_q        <= to_d;
      bus_valid_q <= bus_valid_d;
      bus_read_q  <= bus_read_d;
      bus_write_q <= bus_write_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // FIFO payload storage; contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_bus_master_queued.sv
// Directed bench for bus_master_queued: latency, wait states, queue full,
// timeout, push/pop overlap, pointer wrap and mid-transaction reset.
module tb_bus_master_queued;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        bus_valid;
  logic        bus_ready = 1'b0;
  logic        bus_read;
  logic        bus_write;
  logic [15:0] bus_addr;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data = '0;
  logic        rsp_valid;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [2:0]  cmd_count;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  bus_master_queued #(
    .ADDR_W(16), .DATA_W(32), .CMD_DEPTH(4), .TIMEOUT(15)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_read(bus_read),
    .bus_write(bus_write), .bus_addr(bus_addr), .bus_write_data(bus_write_data),
    .bus_read_data(bus_read_data),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .cmd_count(cmd_count), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic wr, input logic [15:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    step();
    cmd_valid = 1'b0;
  endtask

  // Acts as the slave for one transaction: wa/wd stall cycles per phase.
  task automatic serve(input int wa, input int wd, input logic [15:0] ea,
                       input logic ew, input logic [31:0] ewd, input logic [31:0] rd);
    int n = 0;
    while (bus_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("bus_valid_rise", bus_valid, 1);
    chk("bus_addr", bus_addr, ea);
    chk("bus_write", bus_write, ew);
    chk("bus_read", bus_read, !ew);
    chk("bus_wdata_addr_phase", bus_write_data, ewd);
    bus_ready = 1'b0;
    repeat (wa) step();
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    bus_read_data = rd;
    repeat (wd) step();
    chk("bus_valid_data_phase", bus_valid, 1);
    chk("bus_wdata_data_phase", bus_write_data, ewd);
    chk("rsp_quiet_data_phase", rsp_valid, 0);
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    bus_read_data = '0;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_write", rsp_write, ew);
    chk("rsp_rdata", rsp_rdata, ew ? 32'h0 : rd);
    chk("rsp_error", rsp_error, 0);
    chk("bus_valid_idle_gap", bus_valid, 0);
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_cmd_count", cmd_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_bus_addr", bus_addr, 0);
    reset = 1'b0;
    step();

    // Single read, zero wait states; bus_valid two cycles after the push
    push(1'b0, 16'h0001, 32'h0);
    chk("rd_count_after_push", cmd_count, 1);
    chk("rd_bus_valid_n1", bus_valid, 0);
    step();
    chk("rd_bus_valid_n2", bus_valid, 1);
    chk("rd_count_after_pop", cmd_count, 0);
    serve(0, 0, 16'h0001, 1'b0, 32'h0, 32'hDEACBEFF);
    step();
    chk("rd_rsp_pulse_end", rsp_valid, 0);
    chk("rd_busy_done", busy, 0);

    // Single write, three wait cycles per phase
    push(1'b1, 16'h0010, 32'h12345678);
    serve(3, 3, 16'h0010, 1'b1, 32'h12345678, 32'hAAAA5555);

    // Ready arriving in the would-be abort cycle of each phase wins
    push(1'b1, 16'h0700, 32'h0BADF00D);
    serve(15, 15, 16'h0700, 1'b1, 32'h0BADF00D, 32'h0);

    // Queue full: one command in flight, four queued, fifth refused
    push(1'b0, 16'h0100, 32'h0);
    step();
    chk("full_inflight", bus_valid, 1);
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 16'h0200 + 16'(i);
      cmd_wdata = 32'h0;
      step();
    end
    chk("full_count4", cmd_count, 4);
    chk("full_ready0", cmd_ready, 0);
    cmd_addr = 16'h0204;
    step();
    chk("full_fifth_refused", cmd_count, 4);
    serve(0, 0, 16'h0100, 1'b0, 32'h0, 32'h11110100);
    chk("full_no_passthrough_ready", cmd_ready, 0);
    step();
    chk("full_pop_no_push", cmd_count, 3);
    chk("full_slot_free", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    chk("full_fifth_accepted", cmd_count, 4);
    for (int i = 0; i < 5; i++) begin
      serve(0, 1, 16'h0200 + 16'(i), 1'b0, 32'h0, 32'hC0DE0000 + 32'(i));
    end

    // Timeout on a read with a second read queued behind it
    push(1'b0, 16'h0300, 32'h0);
    push(1'b0, 16'h0301, 32'h0);
    chk("to_addr_entry", bus_valid, 1);
    chk("to_queued", cmd_count, 1);
    repeat (15) step();
    chk("to_no_rsp_yet", rsp_valid, 0);
    chk("to_still_waiting", bus_valid, 1);
    step();
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_error", rsp_error, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    chk("to_rsp_write", rsp_write, 0);
    chk("to_idle", bus_valid, 0);
    chk("to_busy_queued", busy, 1);
    serve(0, 0, 16'h0301, 1'b0, 32'h0, 32'h5A5A0301);

    // Simultaneous push and pop with two commands queued
    push(1'b0, 16'h0400, 32'h0);
    step();
    push(1'b1, 16'h0401, 32'hA0000401);
    push(1'b0, 16'h0402, 32'h0);
    chk("pp_count2", cmd_count, 2);
    serve(0, 0, 16'h0400, 1'b0, 32'h0, 32'h00000400);
    chk("pp_idle_count2", cmd_count, 2);
    push(1'b1, 16'h0403, 32'hA0000403);
    chk("pp_count_unchanged", cmd_count, 2);
    chk("pp_popped_head", bus_addr, 16'h0401);
    serve(0, 0, 16'h0401, 1'b1, 32'hA0000401, 32'h0);
    serve(1, 0, 16'h0402, 1'b0, 32'h0, 32'h00000402);
    serve(0, 2, 16'h0403, 1'b1, 32'hA0000403, 32'h0);

    // Ten sequential commands, pointers wrapping repeatedly
    for (int i = 0; i < 10; i++) begin
      push(i[0], 16'h0500 + 16'(i), 32'hB0000000 + 32'(i));
      serve(i % 3, (i + 1) % 3, 16'h0500 + 16'(i), i[0], 32'hB0000000 + 32'(i),
            32'hE0000000 + 32'(i));
    end

    // Reset during the data phase with two commands queued
    push(1'b0, 16'h0600, 32'h0);
    step();
    push(1'b0, 16'h0601, 32'h0);
    push(1'b0, 16'h0602, 32'h0);
    chk("rstm_count2", cmd_count, 2);
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    chk("rstm_in_data", bus_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstm_bus_valid", bus_valid, 0);
    chk("rstm_count", cmd_count, 0);
    chk("rstm_rsp_valid", rsp_valid, 0);
    chk("rstm_cmd_ready", cmd_ready, 1);
    chk("rstm_bus_addr", bus_addr, 0);
    step();
    chk("rstm_no_rsp_after", rsp_valid, 0);
    step();
    chk("rstm_no_restart", bus_valid, 0);
    chk("rstm_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
